// File: rtl/conv_mac_engine_if.sv
// Job/result handshake bundle for conv_mac_engine: window, kernel and mode in,
// clamped convolution result out.
interface conv_mac_engine_if #(
   parameter int DATA_W = 8,
   parameter int KSIZE  = 3,
   parameter int OUT_W  = 11
);
   localparam int N = KSIZE * KSIZE;

   logic                  in_valid;
   logic                  in_ready;
   logic [N*DATA_W-1:0]   input_data;
   logic [N*DATA_W-1:0]   kernel;
   logic [1:0]            mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [OUT_W-1:0]      out_conv_o;
   logic                  sat_o;

   modport master (
      output in_valid, input_data, kernel, mode, out_ready,
      input  in_ready, out_valid, out_conv_o, sat_o
   );

   modport slave (
      input  in_valid, input_data, kernel, mode, out_ready,
      output in_ready, out_valid, out_conv_o, sat_o
   );
endinterface

// File: rtl/conv_mac_engine.sv
// Sequential KSIZE x KSIZE convolution MAC: one fixed-point tap per cycle,
// then wrap/ReLU/saturate output mapping held until the consumer takes it.
module conv_mac_engine #(
   parameter int DATA_W    = 8,
   parameter int FRAC_BITS = 6,
   parameter int KSIZE     = 3,
   parameter int OUT_W     = 11
) (
   input  logic             clk,
   input  logic             rst,
   conv_mac_engine_if.slave bus,
   output logic             busy
);
   localparam int N      = KSIZE * KSIZE;
   localparam int VEC_W  = N * DATA_W;
   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = 2 * DATA_W + $clog2(N);
   localparam int CNT_W  = $clog2(N + 1);

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                   state;
   logic [VEC_W-1:0]         pix_sh;
   logic [VEC_W-1:0]         wgt_sh;
   logic [1:0]               mode_q;
   logic signed [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]         tap;

   logic signed [DATA_W-1:0] pix_cur;
   logic signed [DATA_W-1:0] wgt_cur;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] term;
   logic signed [ACC_W-1:0]  term_ext;
   logic [OUT_W-1:0]         map_val;
   logic                     map_sat;

   // Window and kernel shift toward the MSB so the current tap is always the top slice.
   assign pix_cur = pix_sh[VEC_W-1 -: DATA_W];
   assign wgt_cur = wgt_sh[VEC_W-1 -: DATA_W];

   always_comb begin
      prod     = PROD_W'(pix_cur) * PROD_W'(wgt_cur);
      term     = prod >>> FRAC_BITS;
      term_ext = {{(ACC_W - PROD_W){term[PROD_W-1]}}, term};
   end

   always_comb begin
      map_val = acc[OUT_W-1:0];
      map_sat = 1'b0;
      case (mode_q)
         2'b01: begin
            if (acc < 0) map_val = '0;
         end
         2'b10: begin
            if (acc > SAT_HI) begin
               map_val = SAT_HI[OUT_W-1:0];
               map_sat = 1'b1;
            end else if (acc < SAT_LO) begin
               map_val = SAT_LO[OUT_W-1:0];
               map_sat = 1'b1;
            end
         end
         2'b11: begin
            if (acc < 0) begin
               map_val = '0;
            end else if (acc > SAT_HI) begin
               map_val = SAT_HI[OUT_W-1:0];
               map_sat = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // The extra MAC cycle at tap == N registers the mapped result, giving N+1 latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         pix_sh         <= '0;
         wgt_sh         <= '0;
         mode_q         <= '0;
         acc            <= '0;
         tap            <= '0;
         bus.in_ready   <= 1'b1;
         bus.out_valid  <= 1'b0;
         bus.out_conv_o <= '0;
         bus.sat_o      <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  pix_sh       <= bus.input_data;
                  wgt_sh       <= bus.kernel;
                  mode_q       <= bus.mode;
                  acc          <= '0;
                  tap          <= '0;
                  bus.in_ready <= 1'b0;
                  busy         <= 1'b1;
                  state        <= MAC;
               end
            end
            MAC: begin
               if (tap == CNT_W'(N)) begin
                  bus.out_conv_o <= map_val;
                  bus.sat_o      <= map_sat;
                  bus.out_valid  <= 1'b1;
                  state          <= DONE;
               end else begin
                  acc    <= acc + term_ext;
                  pix_sh <= pix_sh << DATA_W;
                  wgt_sh <= wgt_sh << DATA_W;
                  tap    <= tap + CNT_W'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: directed corner jobs plus randomized
// jobs compared against an integer-arithmetic convolution model.
module tb_conv_mac_engine;
   localparam int DATA_W    = 8;
   localparam int FRAC_BITS = 6;
   localparam int KSIZE     = 3;
   localparam int OUT_W     = 11;
   localparam int N         = KSIZE * KSIZE;
   localparam int NW        = N * DATA_W;

   logic clk;
   logic rst;
   logic busy;

   int vectors;
   int miscompares;

   conv_mac_engine_if #(.DATA_W(DATA_W), .KSIZE(KSIZE), .OUT_W(OUT_W)) bus ();

   conv_mac_engine #(
      .DATA_W(DATA_W),
      .FRAC_BITS(FRAC_BITS),
      .KSIZE(KSIZE),
      .OUT_W(OUT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Plain integer convolution with per-product floor shift, then the output rule.
   function automatic void model(input logic [NW-1:0] pix, input logic [NW-1:0] ker,
                                 input logic [1:0] md,
                                 output logic [OUT_W-1:0] res, output logic sat);
      int sum, p, w, v, hi, lo;
      logic [DATA_W-1:0] pb, wb;
      sum = 0;
      for (int t = 0; t < N; t++) begin
         pb  = pix[(N-1-t)*DATA_W +: DATA_W];
         wb  = ker[(N-1-t)*DATA_W +: DATA_W];
         p   = int'($signed(pb));
         w   = int'($signed(wb));
         sum = sum + ((p * w) >>> FRAC_BITS);
      end
      hi  = (2 ** (OUT_W - 1)) - 1;
      lo  = -(hi + 1);
      sat = 1'b0;
      v   = sum;
      case (md)
         2'b01: if (sum < 0) v = 0;
         2'b10: begin
            if (sum > hi) begin v = hi; sat = 1'b1; end
            else if (sum < lo) begin v = lo; sat = 1'b1; end
         end
         2'b11: begin
            if (sum < 0) v = 0;
            else if (sum > hi) begin v = hi; sat = 1'b1; end
         end
         default: ;
      endcase
      res = v[OUT_W-1:0];
   endfunction

   function automatic logic [NW-1:0] rand_vec(input bit extreme);
      logic [NW-1:0] r;
      r = NW'({$urandom, $urandom, $urandom});
      if (extreme) begin
         for (int t = 0; t < N; t++) begin
            case ($urandom_range(0, 3))
               0: r[t*DATA_W +: DATA_W] = 8'h7F;
               1: r[t*DATA_W +: DATA_W] = 8'h80;
               2: r[t*DATA_W +: DATA_W] = 8'h81;
               default: ;
            endcase
         end
      end
      return r;
   endfunction

   task automatic scramble_inputs();
      bus.input_data = NW'({$urandom, $urandom, $urandom});
      bus.kernel     = NW'({$urandom, $urandom, $urandom});
      bus.mode       = 2'($urandom);
      bus.in_valid   = 1'($urandom);
   endtask

   // Runs one job; checks latency, busy/in_ready, result stability and release.
   task automatic run_job(input logic [NW-1:0] pix, input logic [NW-1:0] ker,
                          input logic [1:0] md, input int hold,
                          output logic [OUT_W-1:0] res, output logic sat);
      int cyc;
      bit bad;
      logic [OUT_W-1:0] r0;
      logic s0;
      cyc = 0;
      while (bus.in_ready !== 1'b1 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_wait: in_ready=%b required 1 within 50 cycles", bus.in_ready);
      end
      bus.in_valid   = 1'b1;
      bus.input_data = pix;
      bus.kernel     = ker;
      bus.mode       = md;
      bus.out_ready  = 1'b0;
      @(posedge clk); #1;
      scramble_inputs();
      bad = 1'b0;
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 30) begin
         if (bus.in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
         @(posedge clk); #1;
         cyc++;
         scramble_inputs();
      end
      vectors++;
      if (cyc != N + 1) begin
         miscompares++;
         $display("FAIL latency: out_valid after %0d cycles, required %0d", cyc, N + 1);
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL busy_flags: in_ready/busy got 1/0 during MAC, required 0/1");
      end
      r0  = bus.out_conv_o;
      s0  = bus.sat_o;
      bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.out_conv_o !== r0 || bus.sat_o !== s0 ||
             bus.in_ready !== 1'b0)
            bad = 1'b1;
         scramble_inputs();
      end
      if (hold > 0) begin
         vectors++;
         if (bad) begin
            miscompares++;
            $display("FAIL hold_stable: result/valid changed under backpressure, required %h/%b held",
                     r0, s0);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL release: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                  bus.out_valid, bus.in_ready, busy);
      end
      res = r0;
      sat = s0;
   endtask

   task automatic check_model(input logic [NW-1:0] pix, input logic [NW-1:0] ker,
                              input logic [1:0] md, input int hold, input string tag);
      logic [OUT_W-1:0] got, exp_v;
      logic gs, es;
      model(pix, ker, md, exp_v, es);
      run_job(pix, ker, md, hold, got, gs);
      vectors++;
      if (got !== exp_v || gs !== es) begin
         miscompares++;
         $display("FAIL %s: mode=%0d got %h sat=%b, required %h sat=%b", tag, md, got, gs, exp_v, es);
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      scramble_inputs();
      bus.in_valid  = 1'b1;
      repeat (3) begin @(posedge clk); #1; scramble_inputs(); end
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.out_conv_o !== '0 || bus.sat_o !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: out_valid=%b out=%h sat=%b busy=%b, required 0 000 0 0",
                  bus.out_valid, bus.out_conv_o, bus.sat_o, busy);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      rst           = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", bus.in_ready, busy);
      end
   endtask

   task automatic test_directed();
      logic [7:0]       pb  [8] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h7F, 8'h7F, 8'h7F, 8'hFF};
      logic [7:0]       wb  [8] = '{8'h40, 8'hC0, 8'hC0, 8'hC0, 8'h7F, 8'h7F, 8'h7F, 8'h01};
      logic [1:0]       md  [8] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b10};
      logic [OUT_W-1:0] ev  [8] = '{11'h240, 11'h000, 11'h5C0, 11'h5C0, 11'h3FF, 11'd220, 11'h3FF, 11'h7F7};
      logic             es  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [OUT_W-1:0] got;
      logic gs;
      for (int i = 0; i < 8; i++) begin
         run_job({N{pb[i]}}, {N{wb[i]}}, md[i], 0, got, gs);
         vectors++;
         if (got !== ev[i] || gs !== es[i]) begin
            miscompares++;
            $display("FAIL directed_%0d: got %h sat=%b, required %h sat=%b", i, got, gs, ev[i], es[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         check_model(rand_vec(i[0]), rand_vec(i[1]), 2'($urandom), $urandom_range(0, 3), "random");
   endtask

   task automatic test_backpressure();
      check_model(rand_vec(1'b1), rand_vec(1'b0), 2'b10, 5, "backpressure");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         check_model(rand_vec(1'b0), rand_vec(1'b1), 2'(i), 0, "back_to_back");
   endtask

   task automatic test_reset_abort();
      bit bad;
      bus.in_valid   = 1'b1;
      bus.input_data = {N{8'h7F}};
      bus.kernel     = {N{8'h7F}};
      bus.mode       = 2'b10;
      bus.out_ready  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) bad = 1'b1;
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b0;
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL reset_abort: result/busy seen after mid-MAC reset, required idle");
      end
      check_model(rand_vec(1'b1), rand_vec(1'b1), 2'b11, 1, "after_abort");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
